// File: rtl/sreg_pkg.sv
// Shared types for the sreg_ctrl command path: opcode encoding and arbiter FSM states.
// Pure declarations; no timing or backpressure of its own.
package sreg_pkg;

  localparam int DATA_W = 42;
  localparam int CMD_W  = 3;

  typedef enum logic [CMD_W-1:0] {
    PIX_WRITE         = 3'd0,
    PIX_READ          = 3'd1,
    PIX_READ_END      = 3'd2,
    WRITE_PCLK_0      = 3'd3,
    WRITE_PCLK_1      = 3'd4,
    WRITE_FULL_PCLK_0 = 3'd5,
    WRITE_FULL_PCLK_1 = 3'd6,
    SREG_READ         = 3'd7
  } sreg_cmd_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    GAP       = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sreg_cmd_arb_rr_pick.sv
// Combinational round-robin picker with an optional single-index override (used for the lock).
// Zero latency; grant is simply empty when the chosen requester is not asserting.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               mask_en,
  input  logic [IDX_W-1:0]   mask_idx,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  int sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    sel     = 0;
    if (mask_en) begin
      if (req[mask_idx]) begin
        gnt[mask_idx] = 1'b1;
        gnt_idx       = mask_idx;
      end
    end else begin
      // Walk from the farthest offset down so the requester nearest ptr is written last and wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        sel = int'(ptr) + k;
        if (sel >= NUM_REQ) sel = sel - NUM_REQ;
        if (req[sel]) begin
          gnt      = '0;
          gnt[sel] = 1'b1;
          gnt_idx  = IDX_W'(sel);
        end
      end
    end
  end

endmodule

// File: rtl/sreg_cmd_arb.sv
// Round-robin arbiter sharing one sreg_ctrl command port; keeps PIX_READ..PIX_READ_END atomic.
// Issue 1 cycle after accept, response 1 cycle after done; one command in flight, req_ready only in IDLE.
module sreg_cmd_arb
  import sreg_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [CMD_W*NUM_REQ-1:0]  req_cmd,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      ctrl_cmd_valid,
  output logic [CMD_W-1:0]          ctrl_cmd,
  output logic [DATA_W-1:0]         ctrl_data_in,
  input  logic                      ctrl_cmd_ready,
  input  logic [DATA_W-1:0]         ctrl_data_out,
  output logic                      locked
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  arb_state_e         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   owner_nxt;
  logic [IDX_W-1:0]   lock_owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] owner_oh;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               tmo_hit;
  logic               take;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .mask_en  (locked),
    .mask_idx (lock_owner),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  // Grant is held off during reset so no requester sees a phantom accept.
  assign req_ready = (rst_n && state == IDLE) ? gnt : '0;
  assign take      = |(req_valid & req_ready);
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign owner_nxt = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
  assign owner_oh  = NUM_REQ'(1) << owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      owner          <= '0;
      lock_owner     <= '0;
      rr_ptr         <= '0;
      locked         <= 1'b0;
      tmo_cnt        <= '0;
      ctrl_cmd_valid <= 1'b0;
      ctrl_cmd       <= '0;
      ctrl_data_in   <= '0;
      rsp_valid      <= '0;
      rsp_err        <= 1'b0;
      rsp_data       <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            owner          <= gnt_idx;
            ctrl_cmd       <= req_cmd[int'(gnt_idx)*CMD_W +: CMD_W];
            ctrl_data_in   <= req_data[int'(gnt_idx)*DATA_W +: DATA_W];
            ctrl_cmd_valid <= 1'b1;
            tmo_cnt        <= '0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (ctrl_cmd_ready) begin
            ctrl_cmd_valid <= 1'b0;
            state          <= GAP;
          end else if (tmo_hit) begin
            ctrl_cmd_valid <= 1'b0;
            rsp_valid      <= owner_oh;
            rsp_err        <= 1'b1;
            locked         <= 1'b0;
            rr_ptr         <= owner_nxt;
            state          <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        GAP: begin
          // sreg_ctrl may still show the stale ready from before it latched the command.
          tmo_cnt <= '0;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (ctrl_cmd_ready) begin
            rsp_data  <= ctrl_data_out;
            rsp_valid <= owner_oh;
            if (ctrl_cmd == PIX_READ) begin
              locked     <= 1'b1;
              lock_owner <= owner;
            end else if (ctrl_cmd == PIX_READ_END && locked && owner == lock_owner) begin
              locked <= 1'b0;
            end
            if (!locked) rr_ptr <= owner_nxt;
            state <= IDLE;
          end else if (tmo_hit) begin
            rsp_valid <= owner_oh;
            rsp_err   <= 1'b1;
            locked    <= 1'b0;
            rr_ptr    <= owner_nxt;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sreg_cmd_arb.sv
// Directed bench for sreg_cmd_arb with a small sreg_ctrl behavioural model.
// Covers reset, fairness, single read, lock atomicity, timeout abort and mid-transaction reset.
module tb_sreg_cmd_arb;

  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 16;

  localparam logic [41:0] DAT_A = 42'h0AA_AAAA_AAAA;
  localparam logic [41:0] DAT_B = 42'h155_5555_5555;
  localparam logic [41:0] DAT_C = 42'h123_4567_89AB;
  localparam logic [41:0] DAT_D = 42'h0DE_ADBE_EF01;
  localparam logic [41:0] RD_R  = 42'h2A5_5A5A_5A5A;
  localparam logic [41:0] RD_X1 = 42'h3FF_0000_1234;
  localparam logic [41:0] RD_R2 = 42'h0F0_F0F0_F0F0;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [2:0]   cmd0, cmd1;
  logic [41:0]  dat0, dat1;
  logic [5:0]   req_cmd;
  logic [83:0]  req_data;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [41:0]  rsp_data;
  logic         rsp_err;
  logic         ctrl_cmd_valid;
  logic [2:0]   ctrl_cmd;
  logic [41:0]  ctrl_data_in;
  logic         ctrl_cmd_ready;
  logic [41:0]  ctrl_data_out;
  logic         locked;

  int          n_cmp = 0;
  int          n_err = 0;
  int          acc_cnt = 0;
  int          acc0;
  int          lat;
  int          busy_len;
  bit          stuck;
  logic [41:0] rd_val;
  int          m_cnt;

  assign req_cmd  = {cmd1, cmd0};
  assign req_data = {dat1, dat0};

  sreg_cmd_arb #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_cmd        (req_cmd),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .ctrl_cmd_valid (ctrl_cmd_valid),
    .ctrl_cmd       (ctrl_cmd),
    .ctrl_data_in   (ctrl_data_in),
    .ctrl_cmd_ready (ctrl_cmd_ready),
    .ctrl_data_out  (ctrl_data_out),
    .locked         (locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sreg_ctrl model: drops ready on accept, returns it busy_len+1 cycles later unless stuck.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_cmd_ready <= 1'b1;
      ctrl_data_out  <= '0;
      m_cnt          <= 0;
    end else if (ctrl_cmd_ready) begin
      if (ctrl_cmd_valid) begin
        ctrl_cmd_ready <= 1'b0;
        m_cnt          <= busy_len;
        ctrl_data_out  <= rd_val;
      end
    end else if (!stuck) begin
      if (m_cnt == 0) ctrl_cmd_ready <= 1'b1;
      else            m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk)
    if (rst_n && ctrl_cmd_valid && ctrl_cmd_ready) acc_cnt <= acc_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle first, since a grant may already be offered.
  task automatic wait_gnt(input int max);
    int k;
    k = 0;
    #1;
    while (req_ready == '0 && k < max) begin
      @(negedge clk);
      #1;
      k++;
    end
  endtask

  task automatic wait_rsp(input int max, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rsp_valid == '0 && k < max);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    cmd0 = '0; cmd1 = '0; dat0 = '0; dat1 = '0;
    busy_len = 0; stuck = 1'b0; rd_val = '0;

    // Reset values, with requests asserted to prove the grant is masked.
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_cmd_valid", ctrl_cmd_valid, 1'b0);
    chk("rst_cmd", ctrl_cmd, 3'd0);
    chk("rst_data_in", ctrl_data_in, 42'd0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_data", rsp_data, 42'd0);
    chk("rst_locked", locked, 1'b0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: both requesters hold PIX_WRITE.
    cmd0 = 3'd0; cmd1 = 3'd0; dat0 = DAT_A; dat1 = DAT_B;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(20);
      chk("fair_gnt", req_ready, (g % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
      chk("fair_data", ctrl_data_in, (g % 2) ? DAT_B : DAT_A);
      chk("fair_vld", ctrl_cmd_valid, 1'b1);
    end
    req_valid = '0;
    wait_rsp(30, lat);
    chk("fair_last_rsp", rsp_valid, 2'b10);

    // Single SREG_READ from requester 0.
    cmd0 = 3'd7; rd_val = RD_R; busy_len = 2;
    req_valid = 2'b01;
    wait_gnt(20);
    chk("rd_gnt", req_ready, 2'b01);
    acc0 = acc_cnt;
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    chk("rd_rdy_masked", req_ready, 2'b00);
    chk("rd_cmd", ctrl_cmd, 3'd7);
    req_valid = '0;
    wait_rsp(50, lat);
    chk("rd_latency", lat, 5);
    chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rsp_data", rsp_data, RD_R);
    chk("rd_rsp_err", rsp_err, 1'b0);
    chk("rd_accepts", acc_cnt - acc0, 1);
    @(negedge clk);
    chk("rd_pulse_1cyc", rsp_valid, 2'b00);

    // Lock: requester 1 PIX_READ with requester 0 pending.
    cmd0 = 3'd0; dat0 = DAT_C; cmd1 = 3'd1; rd_val = RD_X1; busy_len = 1;
    req_valid = 2'b11;
    wait_gnt(20);
    chk("lk_gnt_pixread", req_ready, 2'b10);
    @(negedge clk);
    cmd1 = 3'd7;
    wait_rsp(50, lat);
    chk("lk_rsp_pixread", rsp_valid, 2'b10);
    chk("lk_set", locked, 1'b1);
    wait_gnt(20);
    chk("lk_gnt_sread", req_ready, 2'b10);
    @(negedge clk);
    chk("lk_cmd_sread", ctrl_cmd, 3'd7);
    cmd1 = 3'd2;
    wait_rsp(50, lat);
    chk("lk_hold", locked, 1'b1);
    wait_gnt(20);
    chk("lk_gnt_end", req_ready, 2'b10);
    @(negedge clk);
    chk("lk_cmd_end", ctrl_cmd, 3'd2);
    req_valid = 2'b01;
    wait_rsp(50, lat);
    chk("lk_rsp_end", rsp_valid, 2'b10);
    chk("lk_clear", locked, 1'b0);
    wait_gnt(20);
    chk("lk_gnt_req0", req_ready, 2'b01);
    @(negedge clk);
    chk("lk_data_req0", ctrl_data_in, DAT_C);
    req_valid = '0;
    wait_rsp(50, lat);
    chk("lk_rsp_req0", rsp_valid, 2'b01);

    // Timeout in WAIT_DONE while requester 0 holds the lock.
    cmd0 = 3'd1; rd_val = RD_X1; busy_len = 0;
    req_valid = 2'b01;
    wait_gnt(20);
    chk("to_gnt_pixread", req_ready, 2'b01);
    @(negedge clk);
    cmd0 = 3'd7; cmd1 = 3'd0; dat1 = DAT_D;
    req_valid = 2'b11;
    wait_rsp(50, lat);
    chk("to_lock_set", locked, 1'b1);
    stuck = 1'b1;
    wait_gnt(20);
    chk("to_gnt_locked", req_ready, 2'b01);
    @(negedge clk);
    wait_rsp(60, lat);
    chk("to_latency", lat, 18);
    chk("to_rsp_valid", rsp_valid, 2'b01);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_data_held", rsp_data, RD_X1);
    chk("to_unlock", locked, 1'b0);
    chk("to_cmd_valid", ctrl_cmd_valid, 1'b0);
    stuck = 1'b0;
    wait_gnt(20);
    chk("to_next_gnt", req_ready, 2'b10);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(60, lat);
    chk("to_next_rsp", rsp_valid, 2'b10);
    chk("to_next_err", rsp_err, 1'b0);

    // Reset during WAIT_DONE with the lock held by requester 1.
    cmd1 = 3'd1; busy_len = 0;
    req_valid = 2'b10;
    wait_gnt(20);
    chk("rs_gnt_pixread", req_ready, 2'b10);
    @(negedge clk);
    cmd1 = 3'd7; rd_val = RD_R2; busy_len = 10;
    wait_rsp(50, lat);
    chk("rs_lock_set", locked, 1'b1);
    wait_gnt(20);
    chk("rs_gnt_sread", req_ready, 2'b10);
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs_req_ready", req_ready, 2'b00);
    chk("rs_cmd_valid", ctrl_cmd_valid, 1'b0);
    chk("rs_cmd", ctrl_cmd, 3'd0);
    chk("rs_data_in", ctrl_data_in, 42'd0);
    chk("rs_rsp_valid", rsp_valid, 2'b00);
    chk("rs_rsp_data", rsp_data, 42'd0);
    chk("rs_locked", locked, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_len = 1;
    wait_gnt(20);
    chk("rs_gnt_after", req_ready, 2'b10);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(50, lat);
    chk("rs_rsp_after", rsp_valid, 2'b10);
    chk("rs_data_after", rsp_data, RD_R2);
    chk("rs_err_after", rsp_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
